decoder_full_arbiter: RTL and testbench

Round-robin scheduler sharing one decoder_full instance (a large combinational 64-coefficient decode/pack datapath) between NUM_REQ block producers, e.g. the Y, Cb and Cr channel pipelines.
- Registers the granted 896-bit block onto the datapath input.
- Holds it for DP_LAT cycles so the datapath can be a multicycle path.
- Captures the 512-bit packed result and returns it with the requester ID over a valid/ready handshake.
- Exactly one block in flight.

---
 rtl/jpeg_pkg.sv | 15 +
 rtl/decoder_full_arbiter_rr_grant.sv | 29 ++
 rtl/decoder_full_arbiter.sv | 123 ++++++++++++
 tb/tb_decoder_full_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and FSM state type for the block decode path.
// Block sizes derive from 64 coefficients of 14-bit codes / 8-bit bytes.
package jpeg_pkg;
  localparam int NCOEF     = 64;
  localparam int CODE_W    = 14;
  localparam int BYTE_W    = 8;
  localparam int BLK_IN_W  = NCOEF * CODE_W;
  localparam int BLK_OUT_W = NCOEF * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUT
  } state_e;
endpackage

// File: rtl/decoder_full_arbiter_rr_grant.sv
// Round-robin priority picker: first set req bit after ptr_i (wrapping).
// Ports: req_i, ptr_i in; gnt_o one-hot, idx_o index, any_o out.
module rr_grant #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/decoder_full_arbiter.sv
// Round-robin share of one multicycle decode datapath between requesters.
// Ports: req_* in/ready, dp_in/dp_out datapath, out_* result, busy, blk_cnt.
module decoder_full_arbiter
  import jpeg_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IN_W    = BLK_IN_W,
  parameter int OUT_W   = BLK_OUT_W,
  parameter int ID_W    = 2,
  parameter int DP_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [IN_W-1:0]         dp_in,
  input  logic [OUT_W-1:0]        dp_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy,
  output logic [15:0]             blk_cnt
);
  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [3:0]         lat_q, lat_d;
  logic [IN_W-1:0]    dp_in_q, dp_in_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        blk_cnt_q, blk_cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  rr_grant #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    lat_d       = lat_q;
    dp_in_d     = dp_in_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    blk_cnt_d   = blk_cnt_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready = gnt;
          dp_in_d   = req_data[int'(gnt_idx)*IN_W +: IN_W];
          id_d      = gnt_idx;
          rr_ptr_d  = gnt_idx;
          lat_d     = 4'(DP_LAT);
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          out_data_d  = dp_out;
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          blk_cnt_d   = blk_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      lat_q       <= '0;
      dp_in_q     <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      lat_q       <= lat_d;
      dp_in_q     <= dp_in_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign dp_in     = dp_in_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_valid = out_valid_q;
  assign blk_cnt   = blk_cnt_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_decoder_full_arbiter.sv
// Bench for decoder_full_arbiter: DP_LAT=1 instance (a) and DP_LAT=3 (b).
// Bench datapaths: (a) combinational, (b) X until settled.
module tb_decoder_full_arbiter;
  localparam int IN_W  = 896;
  localparam int OUT_W = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        a_req_valid, a_req_ready;
  logic [3*IN_W-1:0] a_req_data;
  logic [IN_W-1:0]   a_dp_in;
  logic [OUT_W-1:0]  a_dp_out, a_out_data;
  logic              a_out_valid, a_out_ready, a_busy;
  logic [1:0]        a_out_id;
  logic [15:0]       a_blk_cnt;

  logic [2:0]        b_req_valid, b_req_ready;
  logic [3*IN_W-1:0] b_req_data;
  logic [IN_W-1:0]   b_dp_in;
  logic [OUT_W-1:0]  b_dp_out, b_out_data;
  logic              b_out_valid, b_out_ready, b_busy;
  logic [1:0]        b_out_id;
  logic [15:0]       b_blk_cnt;

  int pass = 0;
  int chk  = 0;
  int a_ptr = 2;
  int b_ptr = 2;
  logic [15:0] a_cnt = 0;
  logic [15:0] b_cnt = 0;

  function automatic logic [OUT_W-1:0] fdp(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] r;
    for (int k = 0; k < 64; k++)
      r[k*8 +: 8] = x[k*14 +: 8] ^ 8'(k * 3 + 1);
    return r;
  endfunction

  function automatic int exp_grant(input logic [2:0] v, input int ptr);
    for (int k = 1; k <= 3; k++)
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  function automatic logic [3*IN_W-1:0] rnd_data();
    logic [3*IN_W-1:0] r;
    for (int i = 0; i < 3 * IN_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  assign a_dp_out = fdp(a_dp_in);

  logic [IN_W-1:0] b_last;
  int b_age = 0;
  always @(negedge clk) begin
    if (b_dp_in !== b_last) begin
      b_last <= b_dp_in;
      b_age  <= 0;
    end else if (b_age < 100) begin
      b_age <= b_age + 1;
    end
  end
  assign b_dp_out = (b_age >= 2) ? fdp(b_dp_in) : {OUT_W{1'bx}};

  decoder_full_arbiter #(.DP_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_data(a_req_data), .dp_in(a_dp_in), .dp_out(a_dp_out),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_id(a_out_id),
    .busy(a_busy), .blk_cnt(a_blk_cnt)
  );

  decoder_full_arbiter #(.DP_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(b_req_data), .dp_in(b_dp_in), .dp_out(b_dp_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_id(b_out_id),
    .busy(b_busy), .blk_cnt(b_blk_cnt)
  );

  task automatic do_block(input logic [2:0] v, input bit keep,
                          input logic [3*IN_W-1:0] d, output int g,
                          output int lat, output logic [OUT_W-1:0] od,
                          output logic [1:0] oid, output bit tmo,
                          output int bad);
    tmo = 0; bad = 0; g = -1; lat = 0; od = '0; oid = '0;
    a_req_data = d;
    a_req_valid = v;
    #1;
    for (int i = 0; i < 20 && a_req_ready == 3'b000; i++) begin
      @(posedge clk); #2;
    end
    if (a_req_ready == 3'b000) begin
      tmo = 1; a_req_valid = '0; return;
    end
    if ($countones(a_req_ready) != 1) bad++;
    for (int i = 0; i < 3; i++) if (a_req_ready[i]) g = i;
    @(posedge clk); #1;
    if (!keep) a_req_valid = '0;
    #1;
    lat = 1;
    while (!a_out_valid && lat < 40) begin
      if (a_req_ready != 3'b000) bad++;
      @(posedge clk); #2;
      lat++;
    end
    if (!a_out_valid) tmo = 1;
    if (a_req_ready != 3'b000) bad++;
    od = a_out_data;
    oid = a_out_id;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    a_req_valid = '0; b_req_valid = '0;
    a_req_data = '0; b_req_data = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); else pass++;
    chk++; if (a_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", a_busy); else pass++;
    chk++; if (a_blk_cnt !== 16'd0) $display("FAIL rst_blk_cnt got=%0d exp=0", a_blk_cnt); else pass++;
    chk++; if (a_dp_in !== '0) $display("FAIL rst_dp_in got=nonzero exp=0"); else pass++;
    chk++; if (a_out_data !== '0 || a_out_id !== 2'd0) $display("FAIL rst_out_data got_id=%0d exp=0", a_out_id); else pass++;
    chk++; if (a_req_ready !== 3'b000) $display("FAIL rst_req_ready got=%b exp=000", a_req_ready); else pass++;
    chk++; if (b_out_valid !== 1'b0 || b_blk_cnt !== 16'd0) $display("FAIL rst_b got_v=%b exp=0", b_out_valid); else pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    a_ptr = 2; b_ptr = 2; a_cnt = 0; b_cnt = 0;
  endtask

  task automatic test_fairness();
    int order[7] = '{0, 1, 2, 0, 1, 2, 0};
    int g, lat, bad;
    bit tmo;
    logic [OUT_W-1:0] od;
    logic [1:0] oid;
    logic [3*IN_W-1:0] d;
    for (int b = 0; b < 7; b++) begin
      d = rnd_data();
      do_block(3'b111, 1'b1, d, g, lat, od, oid, tmo, bad);
      chk++; if (tmo) $display("FAIL fair_timeout blk=%0d got=timeout exp=done", b); else pass++;
      chk++; if (g !== order[b]) $display("FAIL fair_grant blk=%0d got=%0d exp=%0d", b, g, order[b]); else pass++;
      chk++; if (bad !== 0) $display("FAIL fair_onehot blk=%0d got=%0d exp=0", b, bad); else pass++;
      chk++; if (oid !== 2'(order[b])) $display("FAIL fair_id blk=%0d got=%0d exp=%0d", b, oid, order[b]); else pass++;
      chk++; if (od !== fdp(d[order[b]*IN_W +: IN_W])) $display("FAIL fair_data blk=%0d got=%h exp=%h", b, od[63:0], fdp(d[order[b]*IN_W +: IN_W]) & 64'hFFFFFFFFFFFFFFFF); else pass++;
      a_ptr = order[b];
      a_cnt++;
    end
    a_req_valid = '0;
    chk++; if (a_blk_cnt !== a_cnt) $display("FAIL fair_cnt got=%0d exp=%0d", a_blk_cnt, a_cnt); else pass++;
  endtask

  task automatic test_single();
    logic [3*IN_W-1:0] d;
    bit ok;
    d = rnd_data();
    a_req_data = d;
    a_req_valid = 3'b001;
    #1;
    chk++; if (a_req_ready !== 3'b001) $display("FAIL single_ready got=%b exp=001", a_req_ready); else pass++;
    @(posedge clk); #1;
    a_req_valid = '0;
    #1;
    chk++; if (a_out_valid !== 1'b0 || a_busy !== 1'b1) $display("FAIL single_t1 got_v=%b got_busy=%b exp=0/1", a_out_valid, a_busy); else pass++;
    @(posedge clk); #2;
    ok = a_out_valid === 1'b1 && a_out_id === 2'd0 && a_out_data === fdp(d[IN_W-1:0]);
    chk++; if (!ok) $display("FAIL single_t2 got_v=%b got_id=%0d exp=1/0", a_out_valid, a_out_id); else pass++;
    @(posedge clk); #2;
    a_cnt++;
    a_ptr = 0;
    chk++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) $display("FAIL single_done got_v=%b exp=0", a_out_valid); else pass++;
    chk++; if (a_blk_cnt !== a_cnt) $display("FAIL single_cnt got=%0d exp=%0d", a_blk_cnt, a_cnt); else pass++;
  endtask

  task automatic test_backpressure();
    logic [3*IN_W-1:0] d;
    logic [2:0] v;
    logic [OUT_W-1:0] ed;
    int e;
    bit ok;
    v = 3'($urandom_range(1, 7));
    e = exp_grant(v, a_ptr);
    d = rnd_data();
    ed = fdp(d[e*IN_W +: IN_W]);
    a_req_data = d;
    a_out_ready = 1'b0;
    a_req_valid = v;
    #1;
    chk++; if (a_req_ready !== 3'(1 << e)) $display("FAIL bp_grant got=%b exp=%b", a_req_ready, 3'(1 << e)); else pass++;
    @(posedge clk); #2;
    for (int i = 0; i < 10 && !a_out_valid; i++) begin
      @(posedge clk); #2;
    end
    chk++; if (a_out_valid !== 1'b1) $display("FAIL bp_timeout got=%b exp=1", a_out_valid); else pass++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      ok = a_out_valid === 1'b1 && a_out_data === ed && a_out_id === 2'(e);
      chk++; if (!ok) $display("FAIL bp_stable cyc=%0d got_v=%b got_id=%0d exp=1/%0d", c, a_out_valid, a_out_id, e); else pass++;
      chk++; if (a_req_ready !== 3'b000 || a_busy !== 1'b1) $display("FAIL bp_ready cyc=%0d got=%b busy=%b exp=000/1", c, a_req_ready, a_busy); else pass++;
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    a_req_valid = '0;
    #1;
    chk++; if (a_out_valid !== 1'b1) $display("FAIL bp_hold got=%b exp=1", a_out_valid); else pass++;
    @(posedge clk); #2;
    a_cnt++;
    a_ptr = e;
    chk++; if (a_out_valid !== 1'b0 || a_blk_cnt !== a_cnt) $display("FAIL bp_done got_v=%b got_cnt=%0d exp=0/%0d", a_out_valid, a_blk_cnt, a_cnt); else pass++;
  endtask

  task automatic test_dp_lat3();
    logic [3*IN_W-1:0] d;
    logic [2:0] v;
    int e, lat;
    for (int n = 0; n < 3; n++) begin
      v = 3'($urandom_range(1, 7));
      e = exp_grant(v, b_ptr);
      d = rnd_data();
      b_req_data = d;
      b_req_valid = v;
      #1;
      for (int i = 0; i < 10 && b_req_ready == 3'b000; i++) begin
        @(posedge clk); #2;
      end
      chk++; if (b_req_ready !== 3'(1 << e)) $display("FAIL lat3_grant n=%0d got=%b exp=%b", n, b_req_ready, 3'(1 << e)); else pass++;
      @(posedge clk); #1;
      b_req_valid = '0;
      #1;
      lat = 1;
      while (!b_out_valid && lat < 30) begin
        @(posedge clk); #2;
        lat++;
      end
      chk++; if (lat !== 4) $display("FAIL lat3_latency n=%0d got=%0d exp=4", n, lat); else pass++;
      chk++; if (b_out_data !== fdp(d[e*IN_W +: IN_W]) || $isunknown(b_out_data)) $display("FAIL lat3_data n=%0d got=%h exp=%h", n, b_out_data[63:0], fdp(d[e*IN_W +: IN_W]) & 64'hFFFFFFFFFFFFFFFF); else pass++;
      chk++; if (b_out_id !== 2'(e)) $display("FAIL lat3_id n=%0d got=%0d exp=%0d", n, b_out_id, e); else pass++;
      @(posedge clk); #2;
      b_ptr = e;
      b_cnt++;
    end
    chk++; if (b_blk_cnt !== b_cnt) $display("FAIL lat3_cnt got=%0d exp=%0d", b_blk_cnt, b_cnt); else pass++;
  endtask

  task automatic test_reset_mid_settle();
    logic [3*IN_W-1:0] d;
    int g, lat, bad;
    bit tmo;
    logic [OUT_W-1:0] od;
    logic [1:0] oid;
    logic [2:0] vs[2] = '{3'b110, 3'b100};
    int es[2] = '{1, 2};
    a_req_data = rnd_data();
    a_req_valid = 3'b010;
    #1;
    chk++; if (a_req_ready !== 3'b010) $display("FAIL mrst_grant got=%b exp=010", a_req_ready); else pass++;
    @(posedge clk); #1;
    a_req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) $display("FAIL mrst_async got_v=%b busy=%b exp=0/0", a_out_valid, a_busy); else pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    a_ptr = 2; a_cnt = 0; b_ptr = 2; b_cnt = 0;
    chk++; if (a_out_valid !== 1'b0 || a_blk_cnt !== 16'd0 || a_busy !== 1'b0) $display("FAIL mrst_after got_v=%b cnt=%0d exp=0/0", a_out_valid, a_blk_cnt); else pass++;
    for (int n = 0; n < 2; n++) begin
      d = rnd_data();
      do_block(vs[n], 1'b0, d, g, lat, od, oid, tmo, bad);
      chk++; if (tmo || g !== es[n] || lat !== 2) $display("FAIL mrst_next n=%0d got=%0d lat=%0d exp=%0d lat=2", n, g, lat, es[n]); else pass++;
      chk++; if (od !== fdp(d[es[n]*IN_W +: IN_W]) || oid !== 2'(es[n])) $display("FAIL mrst_data n=%0d got_id=%0d exp=%0d", n, oid, es[n]); else pass++;
      a_ptr = es[n];
      a_cnt++;
    end
  endtask

  task automatic test_random();
    logic [3*IN_W-1:0] d;
    logic [2:0] v;
    int g, lat, bad, e;
    bit tmo, keep;
    logic [OUT_W-1:0] od;
    logic [1:0] oid;
    for (int n = 0; n < 24; n++) begin
      v = 3'($urandom_range(1, 7));
      keep = 1'($urandom_range(0, 1));
      e = exp_grant(v, a_ptr);
      d = rnd_data();
      do_block(v, keep, d, g, lat, od, oid, tmo, bad);
      chk++; if (tmo || bad !== 0 || g !== e || lat !== 2) $display("FAIL rnd_grant n=%0d v=%b got=%0d lat=%0d exp=%0d lat=2", n, v, g, lat, e); else pass++;
      chk++; if (od !== fdp(d[e*IN_W +: IN_W]) || oid !== 2'(e)) $display("FAIL rnd_data n=%0d got_id=%0d exp=%0d", n, oid, e); else pass++;
      a_ptr = e;
      a_cnt++;
      chk++; if (a_blk_cnt !== a_cnt) $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, a_blk_cnt, a_cnt); else pass++;
    end
    a_req_valid = '0;
    @(posedge clk); #2;
  endtask

  task automatic test_counter_wrap();
    logic [3*IN_W-1:0] d;
    int g, lat, bad, e;
    bit tmo;
    logic [OUT_W-1:0] od;
    logic [1:0] oid;
    force dut_a.blk_cnt_q = 16'hFFFD;
    #1;
    release dut_a.blk_cnt_q;
    a_cnt = 16'hFFFD;
    for (int n = 0; n < 4; n++) begin
      d = rnd_data();
      e = exp_grant(3'b101, a_ptr);
      do_block(3'b101, 1'b0, d, g, lat, od, oid, tmo, bad);
      a_cnt++;
      a_ptr = e;
      chk++; if (a_blk_cnt !== a_cnt) $display("FAIL wrap_cnt n=%0d got=%h exp=%h", n, a_blk_cnt, a_cnt); else pass++;
      chk++; if (tmo || g !== e || od !== fdp(d[e*IN_W +: IN_W])) $display("FAIL wrap_op n=%0d got=%0d exp=%0d", n, g, e); else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_dp_lat3();
    test_reset_mid_settle();
    test_random();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
